mdr_mem_ctrl: RTL
=================

// Module: mdr_mem_ctrl
// PURPOSE
//  Memory Data Register plus memory-transaction sequencer for the datapath.
//  Sits behind bus-mux source 21: the MDR contents drive MDR_Bus_lines.
//  Loads the MDR from BusMuxOut, or runs read/write handshakes with the
//  variable-latency memory, with ack timeout and error reporting.
// PARAMETERS
//  DATA_W     32   data width, MDR/bus/memory
//  ADDR_W     9    memory address width, taken from MAR low bits
//  TIMEOUT    16   cycles waiting for mem_ack before abort, >=2
// PORTS
//  clock          in   1       sole clock, rising edge
//  clear          in   1       async active-low reset
//  BusMuxOut      in   DATA_W  shared bus value
//  MDR_in         in   1       load MDR this cycle
//  Read           in   1       MDR_in source: 0=BusMuxOut (1 reserved, ignored)
//  mar_addr       in   ADDR_W  address for the transaction
//  rd_req         in   1       start memory read (1-cycle pulse)
//  wr_req         in   1       start memory write of MDR (1-cycle pulse)
//  mem_rdata      in   DATA_W  memory read data, valid with mem_ack
//  mem_ack        in   1       memory completes current access
//  mem_en         out  1       access active
//  mem_we         out  1       1=write access
//  mem_addr       out  ADDR_W  latched address
//  mem_wdata      out  DATA_W  latched write data
//  MDR_Bus_lines  out  DATA_W  MDR contents, to bus mux
//  busy           out  1       transaction in flight (state != IDLE)
//  done           out  1       1-cycle pulse at end of any transaction
//  err            out  1       sticky: timeout or illegal request
// BEHAVIOUR
//  Reset (clear=0, any time, async): state IDLE; MDR, mem_addr, mem_wdata=0;
//   mem_en, mem_we, done, err, timeout count=0. Access aborted, no MDR update.
//  All outputs registered. FSM: IDLE -> RD_WAIT|WR_WAIT -> DONE -> IDLE.
//  IDLE: MDR_in & !Read -> MDR<=BusMuxOut. MDR_in & Read: MDR unchanged.
//   rd_req only: latch mar_addr; enter RD_WAIT; mem_en=1, mem_we=0 next cycle.
//   wr_req only: latch mar_addr; mem_wdata<=MDR (<=BusMuxOut if MDR_in&!Read
//    same cycle); enter WR_WAIT; mem_en=1, mem_we=1 next cycle.
//   A new request clears err.
//   rd_req & wr_req together: no access; err<=1; done pulse next cycle.
//  RD_WAIT/WR_WAIT: mem_en held 1; count increments each cycle.
//   mem_ack: RD_WAIT -> MDR<=mem_rdata on that edge. Both -> mem_en<=0, DONE.
//   No ack and count==TIMEOUT-1: mem_en<=0, err<=1, MDR unchanged, DONE.
//   rd_req/wr_req/MDR_in while busy are ignored; no err set.
//  DONE: done=1 for exactly one cycle; count<=0; -> IDLE.
//   Requests in DONE are ignored.
//  Latency: request edge -> mem_en 1 cycle later. ack at wait cycle k ->
//   done high the following cycle; read data visible on MDR_Bus_lines with done.
//   Minimum request-to-done = 2 cycles with ack in the first wait cycle.
//  mem_ack outside RD_WAIT/WR_WAIT is ignored.
// STRUCTURE
//  Shared package mini_src_pkg: DATA_W, ADDR_W, bus source code
//   BUS_SRC_MDR=5'd21, FSM state encoding (2-bit localparams).
//  One sub-module: mem_timeout_ctr (clear, restart, enable, expired output
//   at TIMEOUT-1). Everything else flat in mdr_mem_ctrl.
// TESTING
//  1 MDR_in=1,Read=0,Bus=32'hDEAD_BEEF in IDLE -> MDR_Bus_lines=DEADBEEF next cycle; busy=0
//  2 rd_req, mar_addr=9'h05A, ack 3 cycles later with rdata=32'h1234_5678 ->
//    mem_en=1, we=0, addr=05A; MDR=12345678; done pulse 1 cycle; busy then 0
//  3 MDR_in (Bus=32'hA5A5_0001) + wr_req same cycle, addr=9'h100, immediate ack ->
//    mem_we=1, mem_wdata=A5A50001, done 2 cycles after request
//  4 rd_req, no ack, TIMEOUT=16 -> mem_en drops after 16 wait cycles; err=1;
//    MDR unchanged; done pulses; next valid rd_req clears err
//  5 rd_req & wr_req same cycle -> mem_en stays 0; err=1; done next cycle;
//    later rd_req/wr_req/MDR_in while busy -> ignored, no effect on addr/MDR
//  6 clear=0 mid RD_WAIT with ack pending -> mem_en=0, MDR=0, IDLE, err=0 immediately

Source files
------------

// File: rtl/mini_src_pkg.sv
// Shared datapath definitions: widths, bus-mux source code for the MDR, and
// the sequencer state encoding used by mdr_mem_ctrl.
package mini_src_pkg;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 9;
   localparam int TIMEOUT = 16;

   localparam logic [4:0] BUS_SRC_MDR = 5'd21;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR_WAIT = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for memory accesses; expired flags the last allowed
// wait cycle (count == TIMEOUT-1) so the sequencer can abort on that edge.
module mem_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clock,
   input  logic clear,
   input  logic restart,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         cnt_q <= '0;
      end else if (restart) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mdr_mem_ctrl.sv
// Memory Data Register and read/write handshake sequencer for the variable
// latency memory, with ack timeout and sticky error reporting.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | MDR loadable from bus; accepts rd_req / wr_req
//   ST_RD_WAIT | read access active, waiting for mem_ack or timeout
//   ST_WR_WAIT | write access active, waiting for mem_ack or timeout
//   ST_DONE    | one-cycle done pulse, counter cleared, back to idle
module mdr_mem_ctrl #(
   parameter int DATA_W  = mini_src_pkg::DATA_W,
   parameter int ADDR_W  = mini_src_pkg::ADDR_W,
   parameter int TIMEOUT = mini_src_pkg::TIMEOUT
) (
   input  logic              clock,
   input  logic              clear,
   input  logic [DATA_W-1:0] BusMuxOut,
   input  logic              MDR_in,
   input  logic              Read,
   input  logic [ADDR_W-1:0] mar_addr,
   input  logic              rd_req,
   input  logic              wr_req,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] MDR_Bus_lines,
   output logic              busy,
   output logic              done,
   output logic              err
);

   import mini_src_pkg::*;

   state_e            state_q;
   logic [DATA_W-1:0] mdr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              mem_en_q;
   logic              mem_we_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;

   logic              waiting;
   logic              ctr_restart;
   logic              expired;
   logic              bus_load;

   assign waiting     = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
   assign ctr_restart = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign bus_load    = MDR_in && !Read;

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clock   (clock),
      .clear   (clear),
      .restart (ctr_restart),
      .enable  (waiting),
      .expired (expired)
   );

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q  <= ST_IDLE;
         mdr_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus_load) begin
                  mdr_q <= BusMuxOut;
               end
               if (rd_req && wr_req) begin
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else if (rd_req) begin
                  addr_q   <= mar_addr;
                  mem_en_q <= 1'b1;
                  mem_we_q <= 1'b0;
                  err_q    <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= ST_RD_WAIT;
               end else if (wr_req) begin
                  addr_q   <= mar_addr;
                  // a same-cycle bus load is what gets written
                  wdata_q  <= bus_load ? BusMuxOut : mdr_q;
                  mem_en_q <= 1'b1;
                  mem_we_q <= 1'b1;
                  err_q    <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= ST_WR_WAIT;
               end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
               if (mem_ack) begin
                  if (state_q == ST_RD_WAIT) begin
                     mdr_q <= mem_rdata;
                  end
                  mem_en_q <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= ST_DONE;
               end else if (expired) begin
                  mem_en_q <= 1'b0;
                  err_q    <= 1'b1;
                  done_q   <= 1'b1;
                  state_q  <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_en        = mem_en_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign MDR_Bus_lines = mdr_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;

endmodule
